// File: rtl/lib_edge_evt_sched_v1_pkg.sv
// Shared definitions for the edge-event scheduler slice.
//   EVT_*_DEF : default channel count, channel-index width and counter width
//   rr_next   : round-robin pointer successor, wrapping N_CH-1 -> 0
package lib_edge_evt_sched_v1_pkg;

  localparam int unsigned EVT_N_CH_DEF  = 4;
  localparam int unsigned EVT_IDX_W_DEF = 2;
  localparam int unsigned EVT_CNT_W_DEF = 16;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n_ch);
    return (idx + 1 >= n_ch) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lib_edge_evt_sched_v1_posedge_flg.sv
// Rising-edge detector for one level input.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   din     : level input
//   flg     : one-cycle pulse in the cycle after din is first sampled high.
//             The history register resets low, so an input already high out
//             of reset produces a pulse.
module lib_posedge_flg_v1
  import lib_edge_evt_sched_v1_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic flg
);

  logic din_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q <= 1'b0;
      flg   <= 1'b0;
    end else begin
      din_q <= din;
      flg   <= din & ~din_q;
    end
  end

endmodule

// File: rtl/lib_edge_evt_sched_v1.sv
// Per-channel rising-edge capture with round-robin serialisation onto a
// single valid/ready event port.
//   clk, reset_n : clock, asynchronous active-low reset
//   en_i         : 1 = detector pulses become pending events, 0 = dropped
//   clr_i        : synchronous clear of pending, overflow, slot, pointer, count
//   data_i       : N_CH level inputs
//   evt_valid    : output slot holds an event
//   evt_ch       : channel index of the presented event
//   evt_ready    : consumer accepts on evt_valid & evt_ready
//   ovf_o        : sticky per-channel overflow (event merged into pending)
//   evt_cnt_o    : wrapping count of accepted events
module lib_edge_evt_sched_v1
  import lib_edge_evt_sched_v1_pkg::*;
#(
  parameter int unsigned N_CH  = EVT_N_CH_DEF,
  parameter int unsigned IDX_W = EVT_IDX_W_DEF,
  parameter int unsigned CNT_W = EVT_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [N_CH-1:0]  data_i,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_ch,
  input  logic             evt_ready,
  output logic [N_CH-1:0]  ovf_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  logic [N_CH-1:0]  flg;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  set_vec;
  logic [N_CH-1:0]  load_mask;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] win_hi;
  logic [IDX_W-1:0] win_lo;
  logic             found_hi;
  logic             found_lo;
  logic             slot_free;
  logic             any_pend;
  logic             load_slot;

  for (genvar g = 0; g < N_CH; g++) begin : g_det
    lib_posedge_flg_v1 u_det (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (data_i[g]),
      .flg     (flg[g])
    );
  end

  // Rotating priority without a variable rotate: the lowest pending index at
  // or above rr_ptr wins; if none, the lowest pending index overall (wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (pending[c] && (c >= 32'(rr_ptr)) && !found_hi) begin
        found_hi = 1'b1;
        win_hi   = IDX_W'(c);
      end
      if (pending[c] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = IDX_W'(c);
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    slot_free = ~evt_valid | evt_ready;
    any_pend  = |pending;
    load_slot = slot_free & any_pend;
    set_vec   = flg & {N_CH{en_i}};
    load_mask = '0;
    if (load_slot) begin
      load_mask[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= '0;
      ovf_o     <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      rr_ptr    <= '0;
      evt_cnt_o <= '0;
    end else if (clr_i) begin
      pending   <= '0;
      ovf_o     <= '0;
      evt_valid <= 1'b0;
      rr_ptr    <= '0;
      evt_cnt_o <= '0;
    end else begin
      // A new pulse on the channel being loaded re-arms it (set wins over
      // clear); a pulse on a channel still waiting merges and flags overflow.
      pending <= (pending & ~load_mask) | set_vec;
      ovf_o   <= ovf_o | (set_vec & pending & ~load_mask);
      if (slot_free) begin
        if (any_pend) begin
          evt_valid <= 1'b1;
          evt_ch    <= winner;
          rr_ptr    <= IDX_W'(rr_next(32'(winner), N_CH));
        end else begin
          evt_valid <= 1'b0;
        end
      end
      if (evt_valid && evt_ready) begin
        evt_cnt_o <= evt_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lib_edge_evt_sched_v1.sv
module tb_lib_edge_evt_sched_v1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en_i = 1'b1;
  logic        clr_i = 1'b0;
  logic [3:0]  data_i = '0;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic        evt_ready = 1'b1;
  logic [3:0]  ovf_o;
  logic [15:0] evt_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] rise;
    int         n;
    logic [1:0] seq [4];
  } vec_t;

  vec_t tbl[8];

  lib_edge_evt_sched_v1 #(.N_CH(4), .IDX_W(2), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (en_i),
    .clr_i     (clr_i),
    .data_i    (data_i),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready),
    .ovf_o     (ovf_o),
    .evt_cnt_o (evt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted event must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'(evt_ch), 32'hFFFF_FFFF);
      end else begin
        chk("event_ch", 32'(evt_ch), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask, input int low);
    data_i = mask;
    tick();
    data_i = '0;
    repeat (low) tick();
  endtask

  task automatic push(input logic [1:0] ch);
    exp_q.push_back(ch);
    exp_cnt++;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(evt_valid), 32'd1);
  endtask

  initial begin
    tbl[0] = '{4'b1000, 1, '{2'd3, 2'd0, 2'd0, 2'd0}};
    tbl[1] = '{4'b1111, 4, '{2'd0, 2'd1, 2'd2, 2'd3}};
    tbl[2] = '{4'b0001, 1, '{2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[3] = '{4'b1111, 4, '{2'd1, 2'd2, 2'd3, 2'd0}};
    tbl[4] = '{4'b0100, 1, '{2'd2, 2'd0, 2'd0, 2'd0}};
    tbl[5] = '{4'b1011, 3, '{2'd3, 2'd0, 2'd1, 2'd0}};
    tbl[6] = '{4'b0011, 2, '{2'd0, 2'd1, 2'd0, 2'd0}};
    tbl[7] = '{4'b1010, 2, '{2'd3, 2'd1, 2'd0, 2'd0}};

    // Reset state
    #12;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch", 32'(evt_ch), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_cnt", 32'(evt_cnt_o), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // T1: single event, two-edge latency, one cycle valid
    push(2'd2);
    data_i = 4'b0100;
    tick();                 // E0
    data_i = '0;
    chk("t1_valid_e0", 32'(evt_valid), 32'd0);
    tick();                 // E1
    chk("t1_valid_e1", 32'(evt_valid), 32'd0);
    tick();                 // E2
    chk("t1_valid_e2", 32'(evt_valid), 32'd1);
    chk("t1_ch_e2", 32'(evt_ch), 32'd2);
    tick();
    chk("t1_valid_after", 32'(evt_valid), 32'd0);
    chk("t1_cnt", 32'(evt_cnt_o), 32'd1);
    repeat (2) tick();

    // Table: bursts under continuous ready, round-robin order
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < tbl[i].n; k++) push(tbl[i].seq[k]);
      pulse(tbl[i].rise, 3);
      drain($sformatf("tbl%0d_drain", i));
      chk($sformatf("tbl%0d_cnt", i), 32'(evt_cnt_o), 32'(exp_cnt));
    end

    // T3: backpressure holds slot stable
    evt_ready = 1'b0;
    pulse(4'b0010, 1);
    wait_valid("t3_valid");
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(evt_valid), 32'd1);
      chk("t3_hold_ch", 32'(evt_ch), 32'd1);
      tick();
    end
    chk("t3_cnt_held", 32'(evt_cnt_o), 32'(exp_cnt));
    push(2'd1);
    evt_ready = 1'b1;
    tick();
    chk("t3_valid_after", 32'(evt_valid), 32'd0);
    chk("t3_cnt", 32'(evt_cnt_o), 32'(exp_cnt));
    drain("t3_drain");

    // T4: overflow on ch3 while slot is blocked by ch0
    evt_ready = 1'b0;
    pulse(4'b0001, 3);
    wait_valid("t4_valid");
    pulse(4'b1000, 3);
    chk("t4_no_ovf_yet", 32'(ovf_o), 32'd0);
    pulse(4'b1000, 3);
    chk("t4_ovf", 32'(ovf_o), 32'b1000);
    push(2'd0);
    push(2'd3);
    evt_ready = 1'b1;
    drain("t4_drain");
    chk("t4_ovf_sticky", 32'(ovf_o), 32'b1000);
    chk("t4_cnt", 32'(evt_cnt_o), 32'(exp_cnt));
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    exp_cnt = 0;
    chk("t4_ovf_clr", 32'(ovf_o), 32'd0);
    chk("t4_cnt_clr", 32'(evt_cnt_o), 32'd0);

    // T5: ch0 pulse arrives in the cycle ch0 is loaded
    evt_ready = 1'b0;
    pulse(4'b0010, 3);
    wait_valid("t5_valid");
    pulse(4'b0001, 3);
    push(2'd1);
    push(2'd0);
    push(2'd0);
    data_i = 4'b0001;
    tick();                 // edge sampling second ch0 rise
    data_i = '0;
    evt_ready = 1'b1;       // next edge: ch0 loaded while flg[0] high
    tick();
    drain("t5_drain");
    chk("t5_ovf", 32'(ovf_o), 32'd0);
    chk("t5_cnt", 32'(evt_cnt_o), 32'(exp_cnt));

    // T6a: en_i low drops pulses
    en_i = 1'b0;
    pulse(4'b0100, 6);
    chk("t6_en_valid", 32'(evt_valid), 32'd0);
    chk("t6_en_ovf", 32'(ovf_o), 32'd0);
    en_i = 1'b1;

    // T6b: clr_i with three events still pending
    evt_ready = 1'b0;
    pulse(4'b1111, 4);
    chk("t6_clr_pre_valid", 32'(evt_valid), 32'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    exp_cnt = 0;
    chk("t6_clr_valid", 32'(evt_valid), 32'd0);
    chk("t6_clr_cnt", 32'(evt_cnt_o), 32'd0);
    evt_ready = 1'b1;
    repeat (5) tick();
    chk("t6_clr_no_drain", 32'(evt_valid), 32'd0);

    // T6c: asynchronous reset mid-operation
    push(2'd2);
    pulse(4'b0100, 3);
    drain("t6_rst_pre_drain");
    chk("t6_rst_pre_cnt", 32'(evt_cnt_o), 32'd1);
    evt_ready = 1'b0;
    pulse(4'b0110, 3);
    wait_valid("t6_rst_pre_valid");
    chk("t6_rst_pre_ch", 32'(evt_ch), 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(evt_valid), 32'd0);
    chk("t6_rst_ch", 32'(evt_ch), 32'd0);
    chk("t6_rst_cnt", 32'(evt_cnt_o), 32'd0);
    chk("t6_rst_ovf", 32'(ovf_o), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    evt_ready = 1'b1;
    repeat (5) tick();
    chk("t6_post_rst_valid", 32'(evt_valid), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
